// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited arbiter sharing one FIFO write port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  per-requester beat available
//   req_data   per-requester beat data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  per-requester beat accepted this cycle (combinational)
//   fifo_full  FIFO full flag
//   fifo_w_en  FIFO write enable (combinational)
//   fifo_data  FIFO write data, granted requester's slice (combinational)
//   grant      registered one-hot grant, zero when idle
//   busy       registered, high while a burst is in progress
//
// Optional feature macro: FIFO_ARB_PRIO_EN
//   When defined, requester 0 wins every idle arbitration it requests and does
//   not advance the round-robin pointer; the rest rotate as usual.

module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [DATA_W-1:0]        fifo_data,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int unsigned IDX_W  = $clog2(NREQ);
  localparam int unsigned BEAT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             r_state,     w_next_state;
  logic [IDX_W-1:0]   r_rr_ptr,    w_next_rr_ptr;
  logic [IDX_W-1:0]   r_grant_idx, w_next_grant_idx;
  logic [BEAT_W-1:0]  r_beat_cnt,  w_next_beat_cnt;
  logic [NREQ-1:0]    r_grant,     w_next_grant;
  logic               r_busy,      w_next_busy;

  logic               w_in_burst;
  logic               w_cur_valid;
  logic               w_accept;
  logic               w_sel_found;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_rr_after;

  assign w_in_burst  = (r_state == BURST);
  assign w_cur_valid = req_valid[r_grant_idx];
  assign w_accept    = w_in_burst & w_cur_valid & ~fifo_full;
  assign w_rr_after  = (r_grant_idx == IDX_W'(NREQ - 1)) ? '0 : r_grant_idx + IDX_W'(1);

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid[0]) begin
      w_sel_found = 1'b1;
    end
`endif
    for (int k = 0; k < int'(NREQ); k++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % int'(NREQ));
      if (!w_sel_found && req_valid[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state     = r_state;
    w_next_rr_ptr    = r_rr_ptr;
    w_next_grant_idx = r_grant_idx;
    w_next_beat_cnt  = r_beat_cnt;
    w_next_grant     = r_grant;
    w_next_busy      = r_busy;
    case (r_state)
      IDLE: begin
        if (w_sel_found) begin
          w_next_state            = BURST;
          w_next_grant_idx        = w_sel_idx;
          w_next_grant            = '0;
          w_next_grant[w_sel_idx] = 1'b1;
          w_next_beat_cnt         = '0;
          w_next_busy             = 1'b1;
        end
      end
      BURST: begin
        if (w_accept) begin
          w_next_beat_cnt = r_beat_cnt + BEAT_W'(1);
        end
        // Drained exit wins over a full-FIFO stall
        if (!w_cur_valid || (w_accept && r_beat_cnt == BEAT_W'(MAX_BURST - 1))) begin
          w_next_state = IDLE;
          w_next_grant = '0;
          w_next_busy  = 1'b0;
`ifdef FIFO_ARB_PRIO_EN
          if (r_grant_idx != '0) begin
            w_next_rr_ptr = w_rr_after;
          end
`else
          w_next_rr_ptr = w_rr_after;
`endif
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_beat_cnt  <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rr_ptr    <= w_next_rr_ptr;
      r_grant_idx <= w_next_grant_idx;
      r_beat_cnt  <= w_next_beat_cnt;
      r_grant     <= w_next_grant;
      r_busy      <= w_next_busy;
    end
  end

  // Zero-latency write path from the granted requester
  always_comb begin
    req_ready = '0;
    fifo_data = '0;
    if (w_in_burst) begin
      req_ready[r_grant_idx] = ~fifo_full;
      fifo_data              = req_data[int'(r_grant_idx)*int'(DATA_W) +: DATA_W];
    end
  end

  assign fifo_w_en = w_accept;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized bench for fifo_wr_arbiter against a
// beat-counting reference model of the arbitration rules.

module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_full;
  logic                   fifo_w_en;
  logic [DATA_W-1:0]      fifo_data;
  logic [NREQ-1:0]        grant;
  logic                   busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_data(fifo_data), .grant(grant), .busy(busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the port, how many beats it has written, whose turn is next
  int m_busy, m_idx, m_cnt, m_rr;

  int              starts[$];
  int              writes;
  logic [NREQ-1:0] prev_grant;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_cnt = 0; m_rr = 0;
  endtask

  task automatic end_burst();
    m_busy = 0;
`ifdef FIFO_ARB_PRIO_EN
    if (m_idx != 0) m_rr = (m_idx + 1) % NREQ;
`else
    m_rr = (m_idx + 1) % NREQ;
`endif
  endtask

  task automatic model_edge();
    int pick;
    pick = -1;
    if (m_busy == 0) begin
`ifdef FIFO_ARB_PRIO_EN
      if (req_valid[0]) pick = 0;
`endif
      for (int k = 0; k < NREQ; k++)
        if (pick < 0 && req_valid[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
      if (pick >= 0) begin
        m_busy = 1; m_idx = pick; m_cnt = 0;
      end
    end else if (!req_valid[m_idx]) begin
      end_burst();
    end else if (!fifo_full) begin
      m_cnt++;
      if (m_cnt == MAX_BURST) end_burst();
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = ($urandom_range(0, 3) != 0);
      req_data[i*DATA_W +: DATA_W] = $urandom;
    end
    fifo_full = ($urandom_range(0, 4) == 0);
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0]   eg, er;
    logic [DATA_W-1:0] ed;
    logic              ew;
    eg = '0; er = '0; ed = '0; ew = 1'b0;
    if (m_busy != 0) begin
      eg[m_idx] = 1'b1;
      if (!fifo_full) er[m_idx] = 1'b1;
      ew = req_valid[m_idx] & ~fifo_full;
      ed = req_data[m_idx*DATA_W +: DATA_W];
    end
    check_eq("grant",     64'(grant),     64'(eg));
    check_eq("busy",      64'(busy),      64'(m_busy != 0));
    check_eq("req_ready", 64'(req_ready), 64'(er));
    check_eq("fifo_w_en", 64'(fifo_w_en), 64'(ew));
    check_eq("fifo_data", 64'(fifo_data), 64'(ed));
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic run_cycle();
    #1;
    check_outputs();
    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < NREQ; i++) if (grant[i]) starts.push_back(i);
    if (fifo_w_en) writes++;
    prev_grant = grant;
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  initial begin
    int exp_seq[5];
    bit pending;
    pending = 0;
    writes = 0;
    prev_grant = '0;
`ifdef FIFO_ARB_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif

    // Reset takes effect before any clock edge
    rst = 1'b1;
    randomize_inputs();
    #1 rst = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      randomize_inputs();
      run_cycle();
    end
    rst = 1'b1;

    // All requesters continuously valid: 5-cycle burst period
    req_valid = '1;
    fifo_full = 1'b0;
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
      run_cycle();
    end
    check_eq("burst_count", 64'(starts.size()), 64'(5));
    for (int i = 0; i < 5 && i < starts.size(); i++)
      check_eq("grant_order", 64'(starts[i]), 64'(exp_seq[i]));
    check_eq("write_count", 64'(writes), 64'(20));

    // Random traffic with occasional async reset mid-burst
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) pending = 1;
      if (pending && m_busy != 0 && m_cnt == 2) begin
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
          randomize_inputs();
          run_cycle();
        end
        rst = 1'b1;
        pending = 0;
      end
      randomize_inputs();
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of a 32-bit FIFO among NREQ requesters using round-robin arbitration with bounded bursts.
- Sits directly in front of the FIFO.
  - Drives the FIFO's w_en and data_in.
  - Observes the FIFO's full flag.
  - Returns a per-requester valid/ready handshake.

Parameters:
- NREQ, 4: number of requesters; legal range 2..16.
- DATA_W, 32: data width; must match the FIFO width.
- MAX_BURST, 4: maximum beats accepted per grant; legal range 1..256.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a beat available.
- req_data  in  NREQ*DATA_W  beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  beat of requester i accepted this cycle; combinational.
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable; combinational.
- fifo_data  out  DATA_W  FIFO write data; combinational mux of the granted requester's slice.
- grant  out  NREQ  one-hot registered grant; all zero when idle.
- busy  out  1  high while in BURST.

Behaviour:
- Reset (asynchronous, rst=0), taking effect without a clock edge:
  - state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0.
  - grant=0, busy=0, req_ready=0, fifo_w_en=0, fifo_data=0.
- State machine has two states, IDLE and BURST.
- IDLE:
  - No beats are accepted.
  - If any req_valid bit is set, select the first requester at or after rr_ptr, searching upward modulo NREQ.
  - On the selection: grant_idx <= selected index, grant <= one-hot of it, beat_cnt <= 0, state <= BURST.
  - This gives exactly one idle bubble cycle between bursts.
- BURST:
  - accept = req_valid[grant_idx] & !fifo_full.
  - req_ready[grant_idx] = !fifo_full; all other req_ready bits are 0.
  - fifo_w_en = accept; fifo_data = slice grant_idx of req_data. fifo_data is 0 when not in BURST.
  - Zero latency: a beat is written into the FIFO on the same edge it is accepted.
  - On accept: beat_cnt <= beat_cnt + 1. The counter is $clog2(MAX_BURST)+1 bits wide and never wraps within a burst.
- Leaving BURST for IDLE happens on either of these:
  - accept while beat_cnt == MAX_BURST-1 (burst complete), or
  - req_valid[grant_idx] == 0 in any BURST cycle (requester drained); no beat is written that cycle.
- On any exit from BURST: rr_ptr <= (grant_idx+1) mod NREQ, grant <= 0, busy <= 0.
- fifo_full in BURST:
  - Stalls the burst: no accept, beat_cnt holds, state holds.
  - There is no timeout; the grant is kept until the FIFO drains.
- The drained-exit check takes precedence over the stall: valid=0 with full=1 still exits.
- Other requesters' valid bits are ignored during BURST.

Optional Feature:
- Macro: FIFO_ARB_PRIO_EN.
- Defined: requester 0 has strict priority in IDLE.
  - If req_valid[0]=1 it is granted regardless of rr_ptr.
  - rr_ptr is not updated when a requester-0 burst ends.
  - Other requesters rotate round-robin among themselves using rr_ptr as normal.
- Undefined: pure round-robin as described above; requester 0 has no special treatment.

Test Plan (NREQ=4, MAX_BURST=4, macro undefined unless stated):
- Reset: hold rst=0 with random inputs -> grant=0, busy=0, fifo_w_en=0, req_ready=0, fifo_data=0, with no clock edge required.
- Single requester: req 2 valid with 6 beats 0xA0..0xA5 -> one bubble, then 4 writes 0xA0..0xA3 on consecutive cycles, IDLE for 1 cycle, re-grant to 2, writes 0xA4 and 0xA5, then exit on valid drop.
- All four requesters continuously valid -> grant sequence 0,1,2,3,0; each burst is 4 writes followed by a 1-cycle bubble (5-cycle period); fifo_data always matches the granted slice.
- fifo_full=1 for 3 cycles after the 2nd beat of a burst -> fifo_w_en=0 and req_ready=0 for those 3 cycles, beat_cnt holds at 2, and the burst still totals exactly 4 beats.
- Requester 1 drops valid after 2 beats while requester 3 is valid -> IDLE, then grant to 3 (rr_ptr=2, no valid at 2).
- Async reset asserted mid-burst (beat_cnt=2) -> all outputs clear immediately; after release, arbitration restarts from rr_ptr=0.
- With FIFO_ARB_PRIO_EN defined: requesters 0 and 2 both continuously valid -> requester 0 is granted every time the arbiter is in IDLE; requester 2 never wins while req 0 stays valid.
